// File: rtl/miriscv_ram_arb_pkg.sv
// Shared types for the two-master RAM arbiter.
//   NUM_MASTERS : number of masters sharing the RAM data port
//   master_id_t : index of a master (1 bit for two masters)
//   mem_req_t   : request payload of one master (we, be, addr, wdata)
//   mem_rsp_t   : response presented to one master (rvalid, rdata, err)
package miriscv_ram_arb_pkg;

    localparam int NUM_MASTERS = 2;

    typedef logic [0:0] master_id_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
    } mem_rsp_t;

endpackage

// File: rtl/miriscv_rr_arb2.sv
// Two-input round-robin arbiter.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   req_i          : per-master request
//   gnt_o          : one-hot grant (combinational)
//   valid_o        : some master is granted this cycle
//   winner_o       : index of the granted master
// The prio register names the master that wins the next contended cycle.
// It only moves on a contended grant, where it is handed to the loser.
module miriscv_rr_arb2
    import miriscv_ram_arb_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [NUM_MASTERS-1:0] req_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic                   valid_o,
    output master_id_t             winner_o
);

    master_id_t prio_reg;
    logic       contended;

    always_comb begin
        contended = req_i[0] & req_i[1];
        valid_o   = |req_i;
        // Uncontended: the single requester (master 1 if req_i[1], else 0).
        if (contended) begin
            winner_o = prio_reg;
        end else begin
            winner_o = req_i[1];
        end
        gnt_o = '0;
        if (valid_o) begin
            gnt_o[winner_o] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prio_reg <= '0;
        end else if (contended) begin
            prio_reg <= ~winner_o;
        end
    end

endmodule

// File: rtl/miriscv_ram_arbiter.sv
// Shares the RAM data port between the core LSU (master 0) and an
// external loader/debug master (master 1).
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   mN_*_i         : master N request (req, we, be, addr, wdata)
//   mN_gnt_o       : combinational grant
//   mN_rvalid_o    : registered response strobe, one cycle after grant
//   mN_rdata_o     : read data (0 unless a valid, non-errored response)
//   mN_err_o       : out-of-range address error
//   ram_*          : native RAM port; ram_rdata_i is valid the cycle
//                    after ram_req_o
// Out-of-range accesses (when ADDR_CHECK=1) are granted but never reach
// the RAM; they get an error response instead.
module miriscv_ram_arbiter
    import miriscv_ram_arb_pkg::*;
#(
    parameter int RAM_SIZE   = 256,
    parameter bit ADDR_CHECK = 1'b1
)
(
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,

    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i
);

    localparam logic [31:0] RAM_LIMIT = 32'(RAM_SIZE);

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] gnt;
    logic                   win_valid;
    master_id_t             winner;
    mem_req_t               m_req [NUM_MASTERS];
    mem_rsp_t               m_rsp [NUM_MASTERS];
    mem_req_t               win_req;
    logic                   in_range;

    logic                   rsp_valid_reg;
    master_id_t             rsp_id_reg;
    logic                   rsp_err_reg;

    assign req      = {m1_req_i, m0_req_i};
    assign m_req[0] = '{we: m0_we_i, be: m0_be_i, addr: m0_addr_i, wdata: m0_wdata_i};
    assign m_req[1] = '{we: m1_we_i, be: m1_be_i, addr: m1_addr_i, wdata: m1_wdata_i};

    miriscv_rr_arb2 u_arb (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .req_i    (req),
        .gnt_o    (gnt),
        .valid_o  (win_valid),
        .winner_o (winner)
    );

    assign m0_gnt_o = gnt[0];
    assign m1_gnt_o = gnt[1];

    // Forwarding mux and address check.
    always_comb begin
        win_req     = m_req[winner];
        in_range    = (ADDR_CHECK == 1'b0) || (win_req.addr < RAM_LIMIT);
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (win_valid) begin
            ram_req_o   = in_range;
            ram_we_o    = win_req.we;
            ram_be_o    = win_req.be;
            ram_addr_o  = win_req.addr;
            ram_wdata_o = win_req.wdata;
        end
    end

    // Every grant yields exactly one response the following cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            rsp_valid_reg <= win_valid;
            rsp_id_reg    <= winner;
            rsp_err_reg   <= win_valid & ~in_range;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_rsp
            logic rv;
            assign rv        = rsp_valid_reg && (rsp_id_reg == master_id_t'(gi));
            assign m_rsp[gi] = '{rvalid: rv,
                                 rdata:  (rv && !rsp_err_reg) ? ram_rdata_i : 32'h0,
                                 err:    rv && rsp_err_reg};
        end
    endgenerate

    assign m0_rvalid_o = m_rsp[0].rvalid;
    assign m0_rdata_o  = m_rsp[0].rdata;
    assign m0_err_o    = m_rsp[0].err;
    assign m1_rvalid_o = m_rsp[1].rvalid;
    assign m1_rdata_o  = m_rsp[1].rdata;
    assign m1_err_o    = m_rsp[1].err;

endmodule

// File: tb/tb_miriscv_ram_arbiter.sv
// Bench for miriscv_ram_arbiter: directed stimulus pushes expected
// responses into a scoreboard; a monitor on the falling edge pops and
// compares them when they fall due. A second instance with the address
// check disabled exercises address wrap-around.
module tb_miriscv_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        load_mem;

    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_req, ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    logic        nc_m0_gnt, nc_m0_rvalid, nc_m0_err, nc_m1_gnt, nc_m1_rvalid, nc_m1_err;
    logic [31:0] nc_m0_rdata, nc_m1_rdata;
    logic        nc_ram_req, nc_ram_we;
    logic [3:0]  nc_ram_be;
    logic [31:0] nc_ram_addr, nc_ram_wdata, nc_ram_rdata;

    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];

    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;

    typedef struct {
        int          due;
        logic        id;
        logic        err;
        logic        chkd;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    miriscv_ram_arbiter #(.RAM_SIZE(256), .ADDR_CHECK(1'b1)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr),
        .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
        .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
        .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
        .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
        .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_be_o(ram_be),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    miriscv_ram_arbiter #(.RAM_SIZE(256), .ADDR_CHECK(1'b0)) dut_nc (
        .clk_i(clk), .rst_n_i(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr),
        .m0_wdata_i(m0_wdata), .m0_gnt_o(nc_m0_gnt), .m0_rvalid_o(nc_m0_rvalid),
        .m0_rdata_o(nc_m0_rdata), .m0_err_o(nc_m0_err),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
        .m1_wdata_i(m1_wdata), .m1_gnt_o(nc_m1_gnt), .m1_rvalid_o(nc_m1_rvalid),
        .m1_rdata_o(nc_m1_rdata), .m1_err_o(nc_m1_err),
        .ram_req_o(nc_ram_req), .ram_we_o(nc_ram_we), .ram_be_o(nc_ram_be),
        .ram_addr_o(nc_ram_addr), .ram_wdata_o(nc_ram_wdata), .ram_rdata_i(nc_ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 256-byte RAM models: registered read of the pre-write word, byte-enabled write.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 64; i++) begin
                mem_a[i] <= 32'h0;
                mem_b[i] <= 32'h0;
            end
            mem_a[0]  <= 32'h0BADF00D;
            mem_a[4]  <= 32'hDEADBEEF;
            mem_a[8]  <= 32'hAAAAAAAA;
            mem_a[63] <= 32'h11223344;
            mem_b[0]  <= 32'h0BADF00D;
        end else begin
            if (ram_req) begin
                ram_rdata <= mem_a[ram_addr[7:2]];
                if (ram_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ram_be[b]) mem_a[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
                    end
                end
            end
            if (nc_ram_req) begin
                nc_ram_rdata <= mem_b[nc_ram_addr[7:2]];
                if (nc_ram_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (nc_ram_be[b]) mem_b[nc_ram_addr[7:2]][8*b +: 8] <= nc_ram_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_m(input int n, input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (n == 0) begin
            m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    // Called at posedge+1 with inputs already applied; checks the
    // combinational grant/RAM side, queues the expected response, and
    // returns at the next posedge+1.
    task automatic step(input logic [1:0] eg, input logic eram, input logic [31:0] eaddr,
                        input logic chkd, input logic [31:0] erd, input logic eerr);
        #2;
        chk("gnt", 32'({m1_gnt, m0_gnt}), 32'(eg));
        chk("ram_req", 32'(ram_req), 32'(eram));
        if (eram) chk("ram_addr", ram_addr, eaddr);
        if (eg != 2'b00) sb.push_back('{due: cyc + 1, id: eg[1], err: eerr, chkd: chkd, rdata: erd});
        @(posedge clk);
        #1;
    endtask

    // Response monitor.
    always @(negedge clk) begin
        exp_t        e;
        logic        a_rv, a_err, o_rv;
        logic [31:0] a_rd, o_rd;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (e.id == 1'b0) begin
                a_rv = m0_rvalid; a_err = m0_err; a_rd = m0_rdata; o_rv = m1_rvalid; o_rd = m1_rdata;
            end else begin
                a_rv = m1_rvalid; a_err = m1_err; a_rd = m1_rdata; o_rv = m0_rvalid; o_rd = m0_rdata;
            end
            chk("rvalid", 32'(a_rv), 32'd1);
            chk("other_rvalid", 32'(o_rv), 32'd0);
            chk("other_rdata", o_rd, 32'h0);
            chk("err", 32'(a_err), 32'(e.err));
            if (e.chkd) chk("rdata", a_rd, e.rdata);
            $display("rsp m%0d err=%0d rdata=%08h cycle=%0d", e.id, a_err, a_rd, cyc);
        end else begin
            chk("idle_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        load_mem = 1'b1;
        set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        load_mem = 1'b0;

        // Reset state: responses silent, grant/RAM side still combinational.
        chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("rst_m0_err", 32'(m0_err), 32'd0);
        chk("rst_m1_err", 32'(m1_err), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        chk("rst_ram_req_idle", 32'(ram_req), 32'd0);
        set_m(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        #1;
        chk("rst_m0_gnt", 32'(m0_gnt), 32'd1);
        chk("rst_ram_req", 32'(ram_req), 32'd1);
        set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Continuous contention: strict alternation starting with m0.
        set_m(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        set_m(1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) step(2'b01, 1'b1, 32'h10, 1'b1, 32'hDEADBEEF, 1'b0);
            else            step(2'b10, 1'b1, 32'h20, 1'b1, 32'hAAAAAAAA, 1'b0);
        end
        set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        // m0 reads 0x10 alone.
        set_m(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        step(2'b01, 1'b1, 32'h10, 1'b1, 32'hDEADBEEF, 1'b0);

        // m1 partial write, then m0 reads the merged word.
        set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_m(1, 1'b1, 1'b1, 4'b0011, 32'h20, 32'h12345678);
        step(2'b10, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0);
        set_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_m(0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        step(2'b01, 1'b1, 32'h20, 1'b1, 32'hAAAA5678, 1'b0);

        // Same address, same cycle: m0 write wins (prio=0), m1 read sees it.
        set_m(0, 1'b1, 1'b1, 4'hF, 32'h30, 32'hCAFEF00D);
        set_m(1, 1'b1, 1'b0, 4'hF, 32'h30, 32'h0);
        step(2'b01, 1'b1, 32'h30, 1'b0, 32'h0, 1'b0);
        set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(2'b10, 1'b1, 32'h30, 1'b1, 32'hCAFEF00D, 1'b0);
        set_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Last in-range byte address is forwarded.
        set_m(0, 1'b1, 1'b0, 4'hF, 32'hFF, 32'h0);
        step(2'b01, 1'b1, 32'hFF, 1'b1, 32'h11223344, 1'b0);

        // Address == RAM_SIZE: error here, wrap-around on the unchecked instance.
        set_m(0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        #1;
        chk("nc_ram_req", 32'(nc_ram_req), 32'd1);
        chk("nc_ram_addr", nc_ram_addr, 32'h100);
        step(2'b01, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        chk("nc_m0_rvalid", 32'(nc_m0_rvalid), 32'd1);
        chk("nc_m0_err", 32'(nc_m0_err), 32'd0);
        chk("nc_m0_rdata_wrap", nc_m0_rdata, 32'h0BADF00D);
        chk("nc_m1_rvalid", 32'({nc_m1_rvalid, nc_m1_err, nc_m0_gnt, nc_m1_gnt}), 32'h0 | 32'({1'b0, 1'b0, 1'b1, 1'b0}));

        // Errored write must not touch the RAM.
        set_m(0, 1'b1, 1'b1, 4'hF, 32'h100, 32'h55555555);
        step(2'b01, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("err_write_mem0", mem_a[0], 32'h0BADF00D);

        // Prio is now 1: the next contended cycle goes to m1. Then a
        // granted m1 read is killed by reset before its response.
        set_m(1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        #2;
        chk("pre_rst_m1_gnt", 32'({m1_gnt, m0_gnt}), 32'd2);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_drop_m1_rvalid", 32'(m1_rvalid), 32'd0);
        set_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // After reset prio=0: m0 wins the first contended cycle.
        set_m(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        set_m(1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        step(2'b01, 1'b1, 32'h10, 1'b1, 32'hDEADBEEF, 1'b0);
        set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(2'b10, 1'b1, 32'h20, 1'b1, 32'hAAAA5678, 1'b0);
        set_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        step(2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(2'b00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
